// File: rtl/button_event_reader_if.sv
// Event stream from button_event_reader to the application consumer.
// Carries the FIFO head (valid/data) downstream and the accept strobe upstream.
// The master side (reader) holds ev_data stable while ev_valid && !ev_ready.
interface button_event_reader_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [4:0] ev_data;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/button_event_reader.sv
// Debounces eight active-low buttons and emits press/long/repeat/release events into a show-ahead FIFO.
// Latency: stable flip on tick t -> btn_state and pending bit at t+1 -> ev_valid at t+2 (empty FIFO).
// Backpressure: FIFO holds head while ev_ready=0; a push into a full FIFO without a pop is dropped and flags overflow.
module button_event_reader #(
  parameter int TICK_DIV       = 8000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 500,
  parameter int REPEAT_TICKS   = 100,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   nbtn,
  output logic [7:0]                   btn_state,
  output logic                         overflow,
  input  logic                         ovf_clr,
  button_event_reader_if.master        ev
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] LONG_V    = HW'(LONG_TICKS);
  localparam logic [RW-1:0] REP_V     = RW'(REPEAT_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_REPEAT} bstate_t;

  logic [7:0]    sync1, sync2, raw;
  logic [TW-1:0] tcnt;
  logic          tick;

  logic [7:0]    stable_q, stable_d;
  bstate_t       st_q   [8];
  bstate_t       st_d   [8];
  logic [DW-1:0] dcnt_q [8];
  logic [DW-1:0] dcnt_d [8];
  logic [HW-1:0] hold_q [8];
  logic [HW-1:0] hold_d [8];
  logic [RW-1:0] rep_q  [8];
  logic [RW-1:0] rep_d  [8];

  // Pending bit 4*i+type; type order press, long, repeat, release matches ev_data[4:3].
  logic [31:0]   pend_q, pend_set, pend_clr;
  logic [4:0]    scan_sel;
  logic          push_vld;
  logic [4:0]    push_dat;

  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, pop, push, drop;

  // Two-flop synchroniser; reset value is the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= nbtn;
      sync2 <= sync1;
    end
  end
  assign raw = ~sync2;

  // Free-running tick divider, one-cycle tick on the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= '0;
    else        tcnt <= tick ? '0 : tcnt + 1'b1;
  end
  assign tick = (tcnt == TICK_LAST);

  // Debounce and per-button event FSM next-state; release wins over long/repeat on the same tick.
  always_comb begin
    logic [HW-1:0] hold_inc;
    logic [RW-1:0] rep_inc;
    stable_d = stable_q;
    pend_set = '0;
    hold_inc = '0;
    rep_inc  = '0;
    for (int i = 0; i < 8; i++) begin
      st_d[i]   = st_q[i];
      dcnt_d[i] = dcnt_q[i];
      hold_d[i] = hold_q[i];
      rep_d[i]  = rep_q[i];
      if (tick) begin
        if (raw[i] == stable_q[i]) begin
          dcnt_d[i] = '0;
        end else if (dcnt_q[i] == DEB_LAST) begin
          dcnt_d[i]   = '0;
          stable_d[i] = raw[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
        hold_inc = (hold_q[i] == LONG_V) ? hold_q[i] : hold_q[i] + 1'b1;
        rep_inc  = (rep_q[i] == REP_V) ? rep_q[i] : rep_q[i] + 1'b1;
        unique case (st_q[i])
          S_IDLE: begin
            if (stable_d[i]) begin
              st_d[i]         = S_PRESSED;
              hold_d[i]       = '0;
              pend_set[4*i+0] = 1'b1;
            end
          end
          S_PRESSED: begin
            if (!stable_d[i]) begin
              st_d[i]         = S_IDLE;
              pend_set[4*i+3] = 1'b1;
            end else if (hold_inc == LONG_V) begin
              st_d[i]         = S_REPEAT;
              rep_d[i]        = '0;
              pend_set[4*i+1] = 1'b1;
            end else begin
              hold_d[i] = hold_inc;
            end
          end
          S_REPEAT: begin
            if (!stable_d[i]) begin
              st_d[i]         = S_IDLE;
              pend_set[4*i+3] = 1'b1;
            end else if (rep_inc == REP_V) begin
              rep_d[i]        = '0;
              pend_set[4*i+2] = 1'b1;
            end else begin
              rep_d[i] = rep_inc;
            end
          end
          default: st_d[i] = S_IDLE;
        endcase
      end
    end
  end

  // Per-button state, debounce counters and pending event bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      pend_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        st_q[i]   <= S_IDLE;
        dcnt_q[i] <= '0;
        hold_q[i] <= '0;
        rep_q[i]  <= '0;
      end
    end else begin
      stable_q <= stable_d;
      pend_q   <= (pend_q & ~pend_clr) | pend_set;
      for (int i = 0; i < 8; i++) begin
        st_q[i]   <= st_d[i];
        dcnt_q[i] <= dcnt_d[i];
        hold_q[i] <= hold_d[i];
        rep_q[i]  <= rep_d[i];
      end
    end
  end
  assign btn_state = stable_q;

  // Scanner: lowest set pending bit is the next event (button index first, then type).
  always_comb begin
    scan_sel = '0;
    for (int b = 31; b >= 0; b--) begin
      if (pend_q[b]) scan_sel = 5'(b);
    end
  end
  assign push_vld = |pend_q;
  assign pend_clr = push_vld ? (32'd1 << scan_sel) : '0;
  assign push_dat = {scan_sel[1:0], scan_sel[4:2]};

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && ev.ev_ready;
  assign push  = push_vld && (!full || pop);
  assign drop  = push_vld && full && !pop;

  // Event FIFO storage, pointers and sticky overflow (a drop beats a same-cycle clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end
  assign ev.ev_valid = !empty;
  assign ev.ev_data  = mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_button_event_reader.sv
// Bench for button_event_reader: directed button scenarios against a tick-level event model.
// Outputs compared every cycle at the falling edge; inputs change 1 time unit after the rising edge.
// Literal checks on the consumed-event log pin the model's timing and ordering.
module tb_button_event_reader;
  localparam int TD = 64;
  localparam int DB = 4;
  localparam int LT = 20;
  localparam int RT = 5;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] nbtn = 8'hFF;
  logic       ovf_clr = 1'b0;
  logic       ev_ready = 1'b1;
  logic [7:0] btn_state;
  logic       overflow;

  button_event_reader_if bus ();
  assign bus.ev_ready = ev_ready;

  button_event_reader #(
    .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .LONG_TICKS(LT), .REPEAT_TICKS(RT), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .nbtn(nbtn), .btn_state(btn_state),
    .overflow(overflow), .ovf_clr(ovf_clr), .ev(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  int         cyc = 0;
  logic [7:0] m_h1 = 8'hFF, m_h2 = 8'hFF;
  int         tphase = 0;
  logic [7:0] m_stable = 8'h00;
  int         m_run [8] = '{default: 0};
  int         m_held[8] = '{default: -1};
  logic [4:0] m_pend[$];
  logic [4:0] m_fifo[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_raw;
  logic [4:0] m_e;
  bit         m_pop, m_drop, m_flip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h1 = 8'hFF; m_h2 = 8'hFF; tphase = 0; m_stable = 8'h00; m_ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin m_run[i] = 0; m_held[i] = -1; end
      m_pend.delete(); m_fifo.delete();
    end else begin
      cyc++;
      m_pop  = (m_fifo.size() > 0) && ev_ready;
      m_drop = 1'b0;
      if (m_pop) void'(m_fifo.pop_front());
      if (m_pend.size() > 0) begin
        m_e = m_pend.pop_front();
        if (m_fifo.size() < FD) m_fifo.push_back(m_e);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (tphase == TD - 1) begin
        tphase = 0;
        m_raw = ~m_h2;
        for (int i = 0; i < 8; i++) begin
          m_flip = 1'b0;
          if (m_raw[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin m_stable[i] = m_raw[i]; m_run[i] = 0; m_flip = 1'b1; end
          end else m_run[i] = 0;
          if (m_flip && m_stable[i]) begin
            m_pend.push_back({2'b00, 3'(i)}); m_held[i] = 0;
          end else if (m_flip) begin
            m_pend.push_back({2'b11, 3'(i)}); m_held[i] = -1;
          end else if (m_stable[i]) begin
            m_held[i]++;
            if (m_held[i] == LT) m_pend.push_back({2'b01, 3'(i)});
            else if (m_held[i] > LT && (m_held[i] - LT) % RT == 0) m_pend.push_back({2'b10, 3'(i)});
          end
        end
      end else tphase++;
      m_h2 = m_h1;
      m_h1 = nbtn;
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic [14:0] c_act, c_exp;
  always @(negedge clk) begin
    if (chk_en) begin
      c_exp = {m_stable, m_fifo.size() > 0, (m_fifo.size() > 0) ? m_fifo[0] : 5'd0, m_ovf};
      c_act = {btn_state, bus.ev_valid, bus.ev_valid ? bus.ev_data : 5'd0, overflow};
      n_chk++;
      if (c_act === c_exp) n_pass++;
      else $display("FAIL cycle %0d outputs {btn,vld,dat,ovf}: got %h expected %h", cyc, c_act, c_exp);
    end
  end

  // ---------------- observation log ----------------
  logic [4:0] log_dat[$];
  int         log_cyc[$];
  bit         ever_valid = 1'b0, ever_b2 = 1'b0, b0_prev = 1'b0;
  int         b0_cnt = 0, b0_rise = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ev_valid && ev_ready) begin log_dat.push_back(bus.ev_data); log_cyc.push_back(cyc); end
      if (bus.ev_valid) ever_valid = 1'b1;
      if (btn_state[2]) ever_b2 = 1'b1;
      if (btn_state[0]) b0_cnt++;
      if (btn_state[0] && !b0_prev) b0_rise = cyc;
      b0_prev = btn_state[0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_log();
    log_dat.delete(); log_cyc.delete();
  endtask

  logic [4:0] exp_lr[7];
  int         exp_dt[7];
  int         k;

  initial begin
    // Reset values
    step(3);
    chk_en = 1'b1;
    check("reset btn_state", btn_state, 0);
    check("reset ev_valid", bus.ev_valid, 0);
    check("reset ev_data", bus.ev_data, 0);
    check("reset overflow", overflow, 0);
    rst_n = 1'b1;
    step(2 * TD);

    // Glitch shorter than the debounce window
    ever_valid = 1'b0; ever_b2 = 1'b0;
    nbtn[2] = 1'b0; step(3 * TD);
    nbtn[2] = 1'b1; step(8 * TD);
    check("glitch ev_valid rose", ever_valid, 0);
    check("glitch btn_state[2] rose", ever_b2, 0);

    // Short press of button 0
    clear_log(); b0_cnt = 0;
    nbtn[0] = 1'b0; step(10 * TD);
    nbtn[0] = 1'b1; step(8 * TD);
    check("short count", log_dat.size(), 2);
    if (log_dat.size() == 2) begin
      check("short press", log_dat[0], 5'b00_000);
      check("short release", log_dat[1], 5'b11_000);
      check("short valid after btn_state", log_cyc[0] - b0_rise, 1);
    end
    check("short btn_state width", b0_cnt, 10 * TD);

    // Long press with repeats on button 5
    clear_log();
    nbtn[5] = 1'b0; step(41 * TD);
    nbtn[5] = 1'b1; step(8 * TD);
    exp_lr = '{5'b00_101, 5'b01_101, 5'b10_101, 5'b10_101, 5'b10_101, 5'b10_101, 5'b11_101};
    exp_dt = '{0, 20, 25, 30, 35, 40, 41};
    check("long count", log_dat.size(), 7);
    if (log_dat.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        check($sformatf("long ev%0d data", i), log_dat[i], exp_lr[i]);
        check($sformatf("long ev%0d ticks", i), log_cyc[i] - log_cyc[0], exp_dt[i] * TD);
      end
    end

    // Release on the same tick the long event falls due on button 6
    clear_log();
    nbtn[6] = 1'b0; step(20 * TD);
    nbtn[6] = 1'b1; step(8 * TD);
    check("prio count", log_dat.size(), 2);
    if (log_dat.size() == 2) check("prio release", log_dat[1], 5'b11_110);

    // Buttons 7 and 1 together
    clear_log();
    nbtn = nbtn & ~8'h82; step(10 * TD);
    nbtn = 8'hFF; step(8 * TD);
    check("simul count", log_dat.size(), 4);
    if (log_dat.size() == 4) begin
      check("simul first", log_dat[0], 5'b00_001);
      check("simul second", log_dat[1], 5'b00_111);
      check("simul spacing", log_cyc[1] - log_cyc[0], 1);
      check("simul rel order", {log_dat[2], log_dat[3]}, {5'b11_001, 5'b11_111});
    end

    // Backpressure: five presses into a four-entry FIFO
    clear_log();
    ev_ready = 1'b0;
    nbtn = 8'hE0; step(8 * TD);
    check("bp overflow set", overflow, 1);
    check("bp head held", {bus.ev_valid, bus.ev_data}, {1'b1, 5'b00_000});
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    check("bp overflow cleared", overflow, 0);
    ev_ready = 1'b1; step(10);
    check("bp drain count", log_dat.size(), 4);
    if (log_dat.size() == 4)
      for (int i = 0; i < 4; i++) check($sformatf("bp drain %0d", i), log_dat[i], {2'b00, 3'(i)});
    nbtn = 8'hFF; step(8 * TD);
    check("bp release count", log_dat.size(), 9);

    // Reset while button 3 is held
    clear_log();
    nbtn[3] = 1'b0; step(6 * TD);
    check("pre-reset btn_state[3]", btn_state[3], 1);
    rst_n = 1'b0; #1;
    check("in-reset outputs", {btn_state, bus.ev_valid, bus.ev_data, overflow}, 0);
    step(3);
    clear_log();
    rst_n = 1'b1;
    k = 0;
    while (!btn_state[3] && k < 1000) begin step(1); k++; end
    check("post-reset press latency", k, DB * TD);
    step(3 * TD);
    check("post-reset event count", log_dat.size(), 1);
    if (log_dat.size() == 1) check("post-reset press", log_dat[0], 5'b00_011);
    nbtn = 8'hFF; step(8 * TD);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
